// File: rtl/gs_mem_pkg.sv
// Shared types and constants for the General Sound DDR3 memory path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gs_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RD_CMD,
      RD_WAIT,
      WR_CMD
   } state_t;

   localparam int LINE_BYTES = 8;

   // DDR3 64-bit word address where GS byte 0 lives.
   localparam logic [28:0] BASE_WORD_DEF = 29'h0700000;

endpackage

// File: rtl/gs_ddram_cache.sv
// One-line (8-byte) read cache between the GS byte port and 64-bit DDR3 Avalon; writes pass through.
// Latency: read hit 0 waits; read miss 1 + busy + DDR3 latency + 1 edges; write 1 + busy + 1 edges.
// Backpressure: ready is dropped until the DDR3 command is accepted (and, for reads, the data returns).
module gs_ddram_cache
   import gs_mem_pkg::*;
#(
   parameter int          AW        = 21,
   parameter logic [28:0] BASE_WORD = BASE_WORD_DEF
)(
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          flush,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    din,
   input  logic          rd,
   input  logic          we,
   output logic [7:0]    dout,
   output logic          ready,
   input  logic          DDRAM_BUSY,
   output logic [7:0]    DDRAM_BURSTCNT,
   output logic [28:0]   DDRAM_ADDR,
   output logic          DDRAM_RD,
   input  logic [63:0]   DDRAM_DOUT,
   input  logic          DDRAM_DOUT_READY,
   output logic [63:0]   DDRAM_DIN,
   output logic [7:0]    DDRAM_BE,
   output logic          DDRAM_WE
);

   localparam int OW = $clog2(LINE_BYTES);
   localparam int TW = AW - OW;

   state_t        state, state_nx;
   logic          valid;
   logic [TW-1:0] tag;
   logic [63:0]   line;
   logic          done_q;
   logic          flush_q;   // flush seen while a fill was in flight
   logic [AW-1:0] addr_q;
   logic [7:0]    din_q;

   logic req, hit, wr_hit, start, complete;

   assign req      = rd | we;
   assign hit      = valid & (tag == addr[AW-1:OW]);
   assign wr_hit   = valid & (tag == addr_q[AW-1:OW]);
   assign start    = (state == IDLE) & req & ~done_q;
   assign complete = ((state == RD_WAIT) & DDRAM_DOUT_READY) |
                     ((state == WR_CMD)  & ~DDRAM_BUSY);

   // Next-state decode: writes always go to DDR3, reads only on a miss.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (start & we)
               state_nx = WR_CMD;
            else if (start & rd & ~hit)
               state_nx = RD_CMD;
         end
         RD_CMD:  if (!DDRAM_BUSY)      state_nx = RD_WAIT;
         RD_WAIT: if (DDRAM_DOUT_READY) state_nx = IDLE;
         WR_CMD:  if (!DDRAM_BUSY)      state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State, line/tag storage, request capture and completion tracking.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         valid   <= 1'b0;
         tag     <= '0;
         line    <= '0;
         done_q  <= 1'b0;
         flush_q <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
      end else begin
         state <= state_nx;

         if (start) begin
            addr_q <= addr;
            din_q  <= din;
         end

         if (flush)
            valid <= 1'b0;

         if (state == IDLE)
            flush_q <= 1'b0;
         else if (flush)
            flush_q <= 1'b1;

         // A flush during the fill still hands the data over, but the line stays invalid.
         if ((state == RD_WAIT) && DDRAM_DOUT_READY) begin
            line  <= DDRAM_DOUT;
            tag   <= addr_q[AW-1:OW];
            valid <= ~(flush | flush_q);
         end

         // Keep the cached copy coherent with the write that DDR3 just accepted.
         if ((state == WR_CMD) && !DDRAM_BUSY && wr_hit)
            line[{addr_q[OW-1:0], 3'b000} +: 8] <= din_q;

         // done_q only survives while the requester keeps its strobe up.
         if (complete)
            done_q <= req;
         else if (!req)
            done_q <= 1'b0;
      end
   end

   assign DDRAM_RD       = (state == RD_CMD);
   assign DDRAM_WE       = (state == WR_CMD);
   assign DDRAM_BURSTCNT = 8'd1;
   assign DDRAM_ADDR     = BASE_WORD + 29'(addr_q[AW-1:OW]);
   assign DDRAM_DIN      = {8{din_q}};
   assign DDRAM_BE       = 8'b1 << addr_q[OW-1:0];

   assign ready = (state == IDLE) & (done_q | ~req | (rd & ~we & hit));

   // Nothing cached and nothing just delivered reads back as open bus.
   assign dout = (valid | done_q) ? line[{addr[OW-1:0], 3'b000} +: 8] : 8'hFF;

endmodule

// File: tb/tb_gs_ddram_cache.sv
// Directed bench for gs_ddram_cache with a small DDR3 Avalon responder.
// Latency: responder returns read data 5 cycles after accepting a command.
// Backpressure: responder holds BUSY for a programmable number of command cycles.
module tb_gs_ddram_cache;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        flush;
   logic [20:0] addr;
   logic [7:0]  din;
   logic        rd;
   logic        we;
   logic [7:0]  dout;
   logic        ready;
   logic        DDRAM_BUSY       = 1'b0;
   logic [7:0]  DDRAM_BURSTCNT;
   logic [28:0] DDRAM_ADDR;
   logic        DDRAM_RD;
   logic [63:0] DDRAM_DOUT       = 64'h8877665544332211;
   logic        DDRAM_DOUT_READY = 1'b0;
   logic [63:0] DDRAM_DIN;
   logic [7:0]  DDRAM_BE;
   logic        DDRAM_WE;

   int n_cmp = 0;
   int n_bad = 0;

   // Responder state
   int          rd_cnt    = 0;
   int          wr_cnt    = 0;
   int          we_cyc    = 0;
   int          pend      = 0;
   int          busy_left = 0;
   logic [28:0] last_rd_addr = '0;
   logic [28:0] last_wr_addr = '0;
   logic [7:0]  last_be      = '0;
   logic [63:0] last_din     = '0;

   gs_ddram_cache dut (
      .clk_sys          (clk_sys),
      .reset_n          (reset_n),
      .flush            (flush),
      .addr             (addr),
      .din              (din),
      .rd               (rd),
      .we               (we),
      .dout             (dout),
      .ready            (ready),
      .DDRAM_BUSY       (DDRAM_BUSY),
      .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
      .DDRAM_ADDR       (DDRAM_ADDR),
      .DDRAM_RD         (DDRAM_RD),
      .DDRAM_DOUT       (DDRAM_DOUT),
      .DDRAM_DOUT_READY (DDRAM_DOUT_READY),
      .DDRAM_DIN        (DDRAM_DIN),
      .DDRAM_BE         (DDRAM_BE),
      .DDRAM_WE         (DDRAM_WE)
   );

   always #5 clk_sys = ~clk_sys;

   // DDR3 responder: decides BUSY and logs accepted commands mid-cycle, ahead of the next edge.
   always @(negedge clk_sys) begin
      DDRAM_DOUT_READY = 1'b0;
      if (pend > 0) begin
         pend = pend - 1;
         if (pend == 0) DDRAM_DOUT_READY = 1'b1;
      end
      if ((DDRAM_RD || DDRAM_WE) && busy_left > 0) begin
         DDRAM_BUSY = 1'b1;
         busy_left  = busy_left - 1;
      end else begin
         DDRAM_BUSY = 1'b0;
      end
      if (DDRAM_WE) we_cyc = we_cyc + 1;
      if (DDRAM_RD && !DDRAM_BUSY) begin
         rd_cnt       = rd_cnt + 1;
         last_rd_addr = DDRAM_ADDR;
         pend         = 5;
      end
      if (DDRAM_WE && !DDRAM_BUSY) begin
         wr_cnt       = wr_cnt + 1;
         last_wr_addr = DDRAM_ADDR;
         last_be      = DDRAM_BE;
         last_din     = DDRAM_DIN;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp = n_cmp + 1;
      if (got !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_sys);
      #2;
   endtask

   // Counts cycles with ready low, starting from the current one.
   task automatic wait_ready(input string tag, output int lowc);
      lowc = 0;
      while (!ready && lowc < 60) begin
         lowc = lowc + 1;
         step();
      end
      chk({tag, "_ready"}, 64'(ready), 64'd1);
   endtask

   int n;

   initial begin
      reset_n = 1'b0;
      flush   = 1'b0;
      addr    = '0;
      din     = '0;
      rd      = 1'b0;
      we      = 1'b0;
      repeat (3) step();

      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_dout",  64'(dout),  64'hFF);
      chk("rst_rd",    64'(DDRAM_RD), 64'd0);
      chk("rst_we",    64'(DDRAM_WE), 64'd0);
      chk("burstcnt",  64'(DDRAM_BURSTCNT), 64'd1);
      reset_n = 1'b1;
      step();

      // Cold read miss at 0x00010
      addr = 21'h00010;
      rd   = 1'b1;
      #1;
      chk("miss_ready0", 64'(ready), 64'd0);
      wait_ready("miss", n);
      chk("miss_lowcyc", 64'(n), 64'd7);
      chk("miss_dout",   64'(dout), 64'h11);
      chk("miss_rdcnt",  64'(rd_cnt), 64'd1);
      chk("miss_addr",   64'(last_rd_addr), 64'h0700002);

      // Held request must not re-issue
      repeat (20) step();
      chk("held_ready", 64'(ready), 64'd1);
      chk("held_rdcnt", 64'(rd_cnt), 64'd1);

      // Drop and re-raise at another byte of the same line
      rd = 1'b0;
      step();
      addr = 21'h00013;
      rd   = 1'b1;
      #1;
      chk("hit_ready", 64'(ready), 64'd1);
      chk("hit_dout",  64'(dout),  64'h44);
      step();
      chk("hit_rdcnt", 64'(rd_cnt), 64'd1);
      rd = 1'b0;
      step();

      // Write with 3 busy cycles, line hit
      busy_left = 3;
      we_cyc    = 0;
      addr = 21'h00012;
      din  = 8'hA5;
      we   = 1'b1;
      #1;
      chk("wr_ready0", 64'(ready), 64'd0);
      wait_ready("wr", n);
      chk("wr_lowcyc", 64'(n), 64'd5);
      chk("wr_wecyc",  64'(we_cyc), 64'd4);
      chk("wr_cnt",    64'(wr_cnt), 64'd1);
      chk("wr_be",     64'(last_be), 64'h04);
      chk("wr_din",    last_din, 64'hA5A5A5A5A5A5A5A5);
      chk("wr_addr",   64'(last_wr_addr), 64'h0700002);
      we = 1'b0;
      step();
      chk("wr_we_low", 64'(DDRAM_WE), 64'd0);
      rd = 1'b1;
      #1;
      chk("wr_hit_ready", 64'(ready), 64'd1);
      chk("wr_hit_dout",  64'(dout),  64'hA5);
      rd = 1'b0;
      step();

      // Flush forces a refetch
      flush = 1'b1;
      step();
      flush = 1'b0;
      addr  = 21'h00013;
      rd    = 1'b1;
      #1;
      chk("fl_ready0", 64'(ready), 64'd0);
      wait_ready("fl", n);
      chk("fl_rdcnt", 64'(rd_cnt), 64'd2);
      chk("fl_dout",  64'(dout), 64'h44);
      rd = 1'b0;
      step();

      // Reset while the read is waiting for data
      addr = 21'h00008;
      rd   = 1'b1;
      step();
      chk("rw_rdcmd", 64'(DDRAM_RD), 64'd1);
      step();
      chk("rw_wait_rd",    64'(DDRAM_RD), 64'd0);
      chk("rw_wait_ready", 64'(ready), 64'd0);
      reset_n = 1'b0;
      rd      = 1'b0;
      #1;
      chk("rw_rst_rd",    64'(DDRAM_RD), 64'd0);
      chk("rw_rst_ready", 64'(ready), 64'd1);
      chk("rw_rst_dout",  64'(dout), 64'hFF);
      step();
      reset_n = 1'b1;
      repeat (8) step();
      chk("late_dout",  64'(dout), 64'hFF);
      chk("late_rdcnt", 64'(rd_cnt), 64'd3);

      // Stray data must not have filled the line
      rd = 1'b1;
      #1;
      chk("late_miss", 64'(ready), 64'd0);
      wait_ready("late", n);
      rd = 1'b0;
      step();

      // Top of the window
      addr = 21'h1FFFF8;
      rd   = 1'b1;
      #1;
      chk("top_ready0", 64'(ready), 64'd0);
      wait_ready("top", n);
      chk("top_addr",  64'(last_rd_addr), 64'h073FFFF);
      chk("top_dout",  64'(dout), 64'h11);
      chk("top_rdcnt", 64'(rd_cnt), 64'd5);
      rd = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
